// File: rtl/sseg_scan_driver.sv
// Multiplexed hex seven-segment scan driver with sign position, blanking,
// leading-zero suppression and tear-free double-buffered updates at frame wrap.
module sseg_scan_driver #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter bit          ACTIVE_LOW  = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic                    neg,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic                    lz_en,
  output logic [0:6]              seg,
  output logic [NUM_DIGITS:0]     dig_en,
  output logic                    frame_done
);

  localparam int unsigned DW = 4 * NUM_DIGITS;
  localparam int unsigned PW = $clog2(REFRESH_DIV);
  localparam int unsigned SW = $clog2(NUM_DIGITS + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] POS_LAST   = SW'(NUM_DIGITS);

  logic [PW-1:0]         presc_q, presc_d;
  logic [SW-1:0]         pos_q, pos_d;
  logic [DW-1:0]         pend_data_q, pend_data_d;
  logic                  pend_neg_q, pend_neg_d;
  logic [NUM_DIGITS-1:0] pend_blank_q, pend_blank_d;
  logic                  pend_lz_q, pend_lz_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [DW-1:0]         shadow_data_q, shadow_data_d;
  logic                  shadow_neg_q, shadow_neg_d;
  logic [NUM_DIGITS-1:0] shadow_blank_q, shadow_blank_d;
  logic                  shadow_lz_q, shadow_lz_d;
  logic [0:6]            seg_q, seg_d;
  logic [NUM_DIGITS:0]   dig_en_q, dig_en_d;
  logic                  frame_done_q;
  logic                  tick_c, wrap_c;

  assign tick_c = (presc_q == PRESC_LAST);
  assign wrap_c = tick_c && (pos_q == POS_LAST);

  // Glyph table, bit 6 = segment a ... bit 0 = segment g.
  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    hex_glyph = 7'b0000000;
    case (nib)
      4'h0: hex_glyph = 7'b1111110;
      4'h1: hex_glyph = 7'b0110000;
      4'h2: hex_glyph = 7'b1101101;
      4'h3: hex_glyph = 7'b1111001;
      4'h4: hex_glyph = 7'b0110011;
      4'h5: hex_glyph = 7'b1011011;
      4'h6: hex_glyph = 7'b1011111;
      4'h7: hex_glyph = 7'b1110000;
      4'h8: hex_glyph = 7'b1111111;
      4'h9: hex_glyph = 7'b1111011;
      4'hA: hex_glyph = 7'b1110111;
      4'hB: hex_glyph = 7'b0011111;
      4'hC: hex_glyph = 7'b1001110;
      4'hD: hex_glyph = 7'b0111101;
      4'hE: hex_glyph = 7'b1001111;
      4'hF: hex_glyph = 7'b1000111;
      default: hex_glyph = 7'b0000000;
    endcase
  endfunction

  // Scan timing plus pending/shadow buffering; shadow only moves at wrap.
  always_comb begin
    presc_d        = tick_c ? '0 : presc_q + PW'(1);
    pos_d          = pos_q;
    pend_data_d    = pend_data_q;
    pend_neg_d     = pend_neg_q;
    pend_blank_d   = pend_blank_q;
    pend_lz_d      = pend_lz_q;
    pend_valid_d   = pend_valid_q;
    shadow_data_d  = shadow_data_q;
    shadow_neg_d   = shadow_neg_q;
    shadow_blank_d = shadow_blank_q;
    shadow_lz_d    = shadow_lz_q;

    if (tick_c) begin
      pos_d = (pos_q == POS_LAST) ? '0 : pos_q + SW'(1);
    end

    if (load) begin
      pend_data_d  = data;
      pend_neg_d   = neg;
      pend_blank_d = blank_mask;
      pend_lz_d    = lz_en;
      pend_valid_d = 1'b1;
    end

    if (wrap_c) begin
      pend_valid_d = 1'b0;
      if (load) begin
        shadow_data_d  = data;
        shadow_neg_d   = neg;
        shadow_blank_d = blank_mask;
        shadow_lz_d    = lz_en;
      end else if (pend_valid_q) begin
        shadow_data_d  = pend_data_q;
        shadow_neg_d   = pend_neg_q;
        shadow_blank_d = pend_blank_q;
        shadow_lz_d    = pend_lz_q;
      end
    end
  end

  // Glyph and position enable for the current scan position, from shadow only.
  always_comb begin
    logic [3:0] nib;
    logic       upper_zero;
    logic       dark;
    seg_d      = '0;
    dig_en_d   = '0;
    nib        = '0;
    upper_zero = 1'b1;
    dark       = 1'b0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      nib        = shadow_data_q[4*i +: 4];
      upper_zero = upper_zero & (nib == 4'h0);
      dark       = shadow_blank_q[i] | (shadow_lz_q & upper_zero & (i != 0));
      if (pos_q == SW'(i)) begin
        dig_en_d[i] = 1'b1;
        seg_d       = dark ? 7'b0000000 : hex_glyph(nib);
      end
    end
    if (pos_q == POS_LAST) begin
      dig_en_d[NUM_DIGITS] = 1'b1;
      seg_d                = shadow_neg_q ? 7'b0000001 : 7'b0000000;
    end
    if (ACTIVE_LOW) begin
      seg_d    = ~seg_d;
      dig_en_d = ~dig_en_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q        <= '0;
      pos_q          <= '0;
      pend_data_q    <= '0;
      pend_neg_q     <= 1'b0;
      pend_blank_q   <= '0;
      pend_lz_q      <= 1'b0;
      pend_valid_q   <= 1'b0;
      shadow_data_q  <= '0;
      shadow_neg_q   <= 1'b0;
      shadow_blank_q <= '0;
      shadow_lz_q    <= 1'b0;
      seg_q          <= {7{ACTIVE_LOW}};
      dig_en_q       <= {(NUM_DIGITS + 1){ACTIVE_LOW}};
      frame_done_q   <= 1'b0;
    end else begin
      presc_q        <= presc_d;
      pos_q          <= pos_d;
      pend_data_q    <= pend_data_d;
      pend_neg_q     <= pend_neg_d;
      pend_blank_q   <= pend_blank_d;
      pend_lz_q      <= pend_lz_d;
      pend_valid_q   <= pend_valid_d;
      shadow_data_q  <= shadow_data_d;
      shadow_neg_q   <= shadow_neg_d;
      shadow_blank_q <= shadow_blank_d;
      shadow_lz_q    <= shadow_lz_d;
      seg_q          <= seg_d;
      dig_en_q       <= dig_en_d;
      frame_done_q   <= wrap_c;
    end
  end

  assign seg        = seg_q;
  assign dig_en     = dig_en_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Scoreboard bench for sseg_scan_driver: expected frames are queued by the
// stimulus and popped by a monitor at every scan position change.
module tb_sseg_scan_driver;

  localparam logic [6:0] G0 = 7'b1111110;
  localparam logic [6:0] G1 = 7'b0110000;
  localparam logic [6:0] G2 = 7'b1101101;
  localparam logic [6:0] G4 = 7'b0110011;
  localparam logic [6:0] G5 = 7'b1011011;
  localparam logic [6:0] GA = 7'b1110111;
  localparam logic [6:0] GF = 7'b1000111;
  localparam logic [6:0] DK = 7'b0000000;
  localparam logic [6:0] MI = 7'b0000001;

  typedef struct packed {
    logic [4:0] dig;
    logic [6:0] seg;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        reset_al;
  logic        load;
  logic        load_al;
  logic [15:0] data;
  logic        neg;
  logic [3:0]  blank_mask;
  logic        lz_en;
  logic [0:6]  seg;
  logic [4:0]  dig_en;
  logic        frame_done;
  logic [0:6]  seg_al;
  logic [4:0]  dig_en_al;
  logic        frame_done_al;

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc;
  exp_t sb[$];

  sseg_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(1'b0)) u_dut (
    .clk(clk), .reset(reset), .load(load), .data(data), .neg(neg),
    .blank_mask(blank_mask), .lz_en(lz_en), .seg(seg), .dig_en(dig_en),
    .frame_done(frame_done)
  );

  sseg_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(1'b1)) u_dut_al (
    .clk(clk), .reset(reset_al), .load(load_al), .data(data), .neg(neg),
    .blank_mask(blank_mask), .lz_en(lz_en), .seg(seg_al), .dig_en(dig_en_al),
    .frame_done(frame_done_al)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Clock edges since the main instance left reset.
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at time %0t", name, act, req, $time);
    end
  endtask

  task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3,
                            input logic [6:0] ss);
    sb.push_back('{dig: 5'b00001, seg: s0});
    sb.push_back('{dig: 5'b00010, seg: s1});
    sb.push_back('{dig: 5'b00100, seg: s2});
    sb.push_back('{dig: 5'b01000, seg: s3});
    sb.push_back('{dig: 5'b10000, seg: ss});
  endtask

  task automatic goto(input int k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic n,
                         input logic [3:0] bm, input logic lz);
    data       = d;
    neg        = n;
    blank_mask = bm;
    lz_en      = lz;
    load       = 1'b1;
    @(posedge clk);
    #1;
    load       = 1'b0;
  endtask

  // Monitor: every position change pops one expected entry; held cycles must keep it.
  initial begin
    logic [4:0] prev_dig;
    logic [6:0] cur_seg;
    int         last_chg;
    bit         have;
    exp_t       e;
    prev_dig = '0;
    cur_seg  = '0;
    last_chg = 0;
    have     = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_dig = '0;
        last_chg = 0;
        have     = 1'b0;
      end else begin
        chk("frame_done", 32'(frame_done), 32'((cyc != 0) && (cyc % 20 == 0)));
        if (dig_en !== prev_dig) begin
          if (last_chg != 0) chk("scan_period", 32'(cyc - last_chg), 32'd4);
          last_chg = cyc;
          if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb_underflow: actual dig_en %b with no expected entry at time %0t",
                     dig_en, $time);
          end else begin
            e = sb.pop_front();
            chk("dig_en", 32'(dig_en), 32'(e.dig));
            chk("seg", 32'(seg), 32'(e.seg));
            cur_seg = e.seg;
            have    = 1'b1;
          end
          prev_dig = dig_en;
        end else if (have) begin
          chk("seg_hold", 32'(seg), 32'(cur_seg));
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: actual timeout required completion at time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    reset_al   = 1'b1;
    load       = 1'b0;
    load_al    = 1'b0;
    data       = '0;
    neg        = 1'b0;
    blank_mask = '0;
    lz_en      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_seg", 32'(seg), 32'h0);
    chk("rst_dig_en", 32'(dig_en), 32'h0);
    chk("rst_frame_done", 32'(frame_done), 32'h0);
    chk("rst_al_seg", 32'(seg_al), 32'h7F);
    chk("rst_al_dig_en", 32'(dig_en_al), 32'h1F);

    push_frame(G0, G0, G0, G0, DK);
    @(negedge clk);
    #1;
    reset    = 1'b0;
    reset_al = 1'b0;

    // Frame 1: load mid-frame, shown from frame 2.
    goto(5);
    do_load(16'h12AF, 1'b1, 4'b0000, 1'b0);
    push_frame(GF, GA, G2, G1, MI);

    // Frame 2: two loads, latest wins.
    goto(25);
    do_load(16'h1111, 1'b0, 4'b0000, 1'b0);
    goto(30);
    do_load(16'h2222, 1'b0, 4'b0000, 1'b0);
    push_frame(G2, G2, G2, G2, DK);

    // Active-low instance: reset mid-frame, then first edge after release.
    goto(45);
    reset_al = 1'b1;
    #1;
    chk("al_mid_rst_seg", 32'(seg_al), 32'h7F);
    chk("al_mid_rst_dig_en", 32'(dig_en_al), 32'h1F);
    chk("al_mid_rst_frame_done", 32'(frame_done_al), 32'h0);
    @(negedge clk);
    #1;
    reset_al = 1'b0;
    @(posedge clk);
    #1;
    chk("al_first_seg", 32'(seg_al), 32'h01);
    chk("al_first_dig_en", 32'(dig_en_al), 32'h1E);

    // Load coincident with the wrap cycle goes straight to the next frame.
    goto(59);
    do_load(16'h0005, 1'b0, 4'b0000, 1'b0);
    push_frame(G5, G0, G0, G0, DK);

    // Leading-zero suppression combined with a blank mask.
    goto(65);
    do_load(16'h0040, 1'b0, 4'b0001, 1'b1);
    push_frame(DK, G4, DK, DK, DK);
    push_frame(DK, G4, DK, DK, DK);

    // Pending load discarded by a mid-frame reset.
    goto(105);
    do_load(16'h9999, 1'b1, 4'b0000, 1'b0);
    goto(110);
    reset = 1'b1;
    #1;
    chk("mid_rst_seg", 32'(seg), 32'h0);
    chk("mid_rst_dig_en", 32'(dig_en), 32'h0);
    chk("mid_rst_frame_done", 32'(frame_done), 32'h0);
    sb.delete();
    push_frame(G0, G0, G0, G0, DK);
    push_frame(G0, G0, G0, G0, DK);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    reset = 1'b0;

    goto(40);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sseg_scan_driver.md
SSEG_SCAN_DRIVER -- requirements
Module: sseg_scan_driver

Interface
REQ-001 Parameter NUM_DIGITS, default 4, SHALL set the number of hex digit positions (range 1..8).
REQ-002 Parameter REFRESH_DIV, default 50000, SHALL set clocks per scan position (range 2..2^20).
REQ-003 Parameter ACTIVE_LOW, default 0, SHALL invert seg and dig_en when 1.
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 load  in  1  one-cycle request to capture data, neg, blank_mask, lz_en.
REQ-007 data  in  4*NUM_DIGITS  hex digits; nibble 0 = rightmost position.
REQ-008 neg  in  1  lights the sign position with "-".
REQ-009 blank_mask  in  NUM_DIGITS  bit i=1 forces digit i dark.
REQ-010 lz_en  in  1  enables leading-zero suppression.
REQ-011 seg  out  [0:6]  registered segments a..g, bit 0 = a.
REQ-012 dig_en  out  NUM_DIGITS+1  registered one-hot position enable; bit NUM_DIGITS = sign position.
REQ-013 frame_done  out  1  one-cycle pulse at each frame wrap.

Function
REQ-014 Prescaler SHALL count 0..REFRESH_DIV-1 and wrap; tick = (prescaler == REFRESH_DIV-1).
REQ-015 Position counter pos SHALL advance by 1 on tick, 0..NUM_DIGITS, wrapping NUM_DIGITS -> 0.
REQ-016 Wrap = tick while pos == NUM_DIGITS; frame_done SHALL be 1 on the clock edge after the wrap cycle, for exactly one cycle.
REQ-017 load SHALL capture inputs into a pending register and set pending_valid; a later load before wrap SHALL overwrite pending (latest wins).
REQ-018 On wrap: if load is also asserted, shadow SHALL take the current inputs directly; else if pending_valid, shadow SHALL take pending; pending_valid SHALL clear in both cases.
REQ-019 Displayed content SHALL come only from shadow; shadow SHALL never change except at wrap (no mid-frame tearing).
REQ-020 Each cycle, seg/dig_en SHALL register the glyph and one-hot for the current pos (1-cycle latency from pos).
REQ-021 Hex glyphs (abcdefg): 0 1111110, 1 0110000, 2 1101101, 3 1111001, 4 0110011, 5 1011011, 6 1011111, 7 1110000, 8 1111111, 9 1111011, A 1110111, b 0011111, C 1001110, d 0111101, E 1001111, F 1000111.
REQ-022 Sign position SHALL show 0000001 when shadow neg = 1, else 0000000.
REQ-023 Digit i SHALL be dark (0000000, dig_en bit still asserted) when blank_mask[i] = 1.
REQ-024 With lz_en = 1, digit i (i >= 1) SHALL be dark when it and all digits above it are 0; digit 0 SHALL always display.
REQ-025 Blanking rules SHALL be evaluated on shadow values only.
REQ-026 With ACTIVE_LOW = 1, seg and dig_en SHALL be bitwise inverted after all above rules.

Reset
REQ-027 While reset = 1: prescaler = 0, pos = 0, pending and shadow (data, neg, blank_mask, lz_en) = 0, pending_valid = 0, frame_done = 0.
REQ-028 While reset = 1: seg = all segments off and dig_en = all off (all 1s if ACTIVE_LOW = 1).
REQ-029 First edge after reset release SHALL present dig_en = position 0 with glyph "0".
REQ-030 Reset mid-frame SHALL discard any pending load.

Verification (NUM_DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=0 unless stated)
REQ-031 Reset release, no load -> dig_en walks 00001,00010,00100,01000,10000 every 4 clocks; seg 1111110 on positions 0..3, 0000000 on sign; frame_done pulses every 20 clocks.
REQ-032 load data=16'h12AF, neg=1 at pos 1 -> seg unchanged until wrap; next frame shows F 1000111, A 1110111, 2 1101101, 1 0110000, sign 0000001.
REQ-033 Two loads (16'h1111 then 16'h2222) within one frame -> next frame shows all 1101101 only.
REQ-034 load 16'h0005 coincident with wrap cycle -> frame starting that wrap shows 5 at digit 0.
REQ-035 lz_en=1, data=16'h0040, blank_mask=4'b0001 -> digit 3 dark, digit 2 dark, digit 1 0110011, digit 0 dark.
REQ-036 ACTIVE_LOW=1 and reset asserted mid-frame -> seg = 1111111, dig_en = 11111 immediately; after release, digit 0 shows 0000001 with dig_en = 11110.
